// File: rtl/ball_motion_if.sv
// Ball engine bundle: game/collision inputs toward the engine, ball state back to the blocks.
// master = ball_motion engine, slave = playfield side (blocks, paddle, key logic).
interface ball_motion_if;
  logic       start;
  logic       tick_ext;
  logic       hit_up;
  logic       hit_down;
  logic       hit_left;
  logic       hit_right;
  logic       hit_bar;
  logic [9:0] x_ball;
  logic [9:0] y_ball;
  logic [9:0] next_x;
  logic [9:0] next_y;
  logic       dir_x;
  logic       dir_y;
  logic       ball_lost;
  logic [1:0] lives;
  logic       game_over;

  modport master (
    input  start, tick_ext, hit_up, hit_down, hit_left, hit_right, hit_bar,
    output x_ball, y_ball, next_x, next_y, dir_x, dir_y, ball_lost, lives, game_over
  );

  modport slave (
    output start, tick_ext, hit_up, hit_down, hit_left, hit_right, hit_bar,
    input  x_ball, y_ball, next_x, next_y, dir_x, dir_y, ball_lost, lives, game_over
  );
endinterface

// File: rtl/ball_motion.sv
// Breakout ball engine: moves the ball one step per tick, reflects off blocks/paddle/walls,
// tracks lives. Define BALL_TICK_EXT_EN to step on tick_ext instead of the internal divider.
module ball_motion #(
  parameter int unsigned R_BALL   = 8,
  parameter int unsigned H_RES    = 640,
  parameter int unsigned V_RES    = 480,
  parameter int unsigned X_START  = 320,
  parameter int unsigned Y_START  = 400,
  parameter int unsigned STEP     = 1,
  parameter int unsigned TICK_DIV = 250000,
  parameter int unsigned LIVES    = 3
) (
  input  logic          clock,
  input  logic          reset,
  ball_motion_if.master bus
);

  localparam logic [9:0] XMin       = 10'(R_BALL);
  localparam logic [9:0] XMax       = 10'(H_RES - 1 - R_BALL);
  localparam logic [9:0] YMin       = 10'(R_BALL);
  localparam logic [9:0] YMax       = 10'(V_RES - 1 - R_BALL);
  localparam logic [9:0] XStart     = 10'(X_START);
  localparam logic [9:0] YStart     = 10'(Y_START);
  localparam logic [9:0] XStartNext = 10'(X_START + STEP);
  localparam logic [9:0] YStartNext = 10'(Y_START - STEP);
  localparam logic [1:0] LivesInit  = 2'(LIVES);

  typedef enum logic [1:0] {StIdle, StRun, StLost, StOver} state_e;

  state_e     state_q, state_d;
  logic [9:0] x_q, x_d, y_q, y_d, nx_q, nx_d, ny_q, ny_d;
  logic       dir_x_q, dir_x_d, dir_y_q, dir_y_d;
  logic       dir_x_new, dir_y_new;
  logic [1:0] lives_q, lives_d;
  logic       start_q;
  logic       tick;
  logic       lose;

  // Signed arithmetic so a step past either edge clamps instead of wrapping.
  function automatic logic [9:0] step_clamp(logic [9:0] p, logic dir, logic [9:0] lo,
                                            logic [9:0] hi);
    int v;
    v = dir ? int'(p) + int'(STEP) : int'(p) - int'(STEP);
    if (v < int'(lo)) v = int'(lo);
    else if (v > int'(hi)) v = int'(hi);
    return 10'(v);
  endfunction

`ifdef BALL_TICK_EXT_EN
  assign tick = bus.tick_ext & (state_q == StRun);
`else
  localparam int unsigned CntW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            unused_tick_ext;
  assign unused_tick_ext = bus.tick_ext;

  always_comb begin
    cnt_d = '0;
    tick  = 1'b0;
    if (state_q == StRun) begin
      if (cnt_q == CntW'(TICK_DIV - 1)) tick = 1'b1;
      else cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
`endif

  // Block/paddle hits outrank the wall rules on the same axis.
  always_comb begin
    dir_y_new = dir_y_q;
    if (bus.hit_up && bus.hit_down)     dir_y_new = ~dir_y_q;
    else if (bus.hit_up || bus.hit_bar) dir_y_new = 1'b0;
    else if (bus.hit_down)              dir_y_new = 1'b1;
    else if (y_q <= YMin)               dir_y_new = 1'b1;

    dir_x_new = dir_x_q;
    if (bus.hit_left && bus.hit_right) dir_x_new = ~dir_x_q;
    else if (bus.hit_left)             dir_x_new = 1'b0;
    else if (bus.hit_right)            dir_x_new = 1'b1;
    else if (x_q <= XMin)              dir_x_new = 1'b1;
    else if (x_q >= XMax)              dir_x_new = 1'b0;

    lose = (y_q >= YMax) && !bus.hit_bar;
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    nx_d    = nx_q;
    ny_d    = ny_q;
    dir_x_d = dir_x_q;
    dir_y_d = dir_y_q;
    lives_d = lives_q;
    unique case (state_q)
      StIdle: if (bus.start && !start_q) state_d = StRun;
      StRun: begin
        if (tick && lose) begin
          state_d = StLost;
          lives_d = lives_q - 2'd1;
        end else begin
          if (tick) begin
            dir_x_d = dir_x_new;
            dir_y_d = dir_y_new;
            x_d     = step_clamp(x_q, dir_x_new, XMin, XMax);
            y_d     = step_clamp(y_q, dir_y_new, YMin, YMax);
            nx_d    = step_clamp(x_d, dir_x_new, XMin, XMax);
            ny_d    = step_clamp(y_d, dir_y_new, YMin, YMax);
          end
          if (!bus.start) state_d = StIdle;
        end
      end
      StLost: begin
        x_d     = XStart;
        y_d     = YStart;
        nx_d    = XStartNext;
        ny_d    = YStartNext;
        dir_x_d = 1'b1;
        dir_y_d = 1'b0;
        state_d = (lives_q == 2'd0) ? StOver : StIdle;
      end
      StOver: state_d = StOver;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
      x_q     <= XStart;
      y_q     <= YStart;
      nx_q    <= XStartNext;
      ny_q    <= YStartNext;
      dir_x_q <= 1'b1;
      dir_y_q <= 1'b0;
      lives_q <= LivesInit;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      nx_q    <= nx_d;
      ny_q    <= ny_d;
      dir_x_q <= dir_x_d;
      dir_y_q <= dir_y_d;
      lives_q <= lives_d;
      start_q <= bus.start;
    end
  end

  assign bus.x_ball    = x_q;
  assign bus.y_ball    = y_q;
  assign bus.next_x    = nx_q;
  assign bus.next_y    = ny_q;
  assign bus.dir_x     = dir_x_q;
  assign bus.dir_y     = dir_y_q;
  assign bus.lives     = lives_q;
  assign bus.ball_lost = (state_q == StLost);
  assign bus.game_over = (state_q == StOver);

endmodule

// File: tb/tb_ball_motion.sv
// Randomized bench for ball_motion against a per-cycle behavioural game model.
module tb_ball_motion;
  localparam int TD   = 4;
  localparam int R    = 8;
  localparam int H    = 640;
  localparam int V    = 480;
  localparam int XS   = 320;
  localparam int YS   = 400;
  localparam int LV   = 3;
  localparam int XMAX = H - 1 - R;
  localparam int YMAX = V - 1 - R;
  localparam int MIdle = 0, MRun = 1, MLost = 2, MOver = 3;

  logic clock = 1'b0;
  logic reset;
  ball_motion_if bus();

  ball_motion #(.TICK_DIV(TD)) dut (.clock(clock), .reset(reset), .bus(bus));

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  int m_mode, m_cnt, m_x, m_y, m_dx, m_dy, m_lives, m_sq, n_lost;
  bit m_tick;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int clampi(input int v, input int lo, input int hi);
    return (v < lo) ? lo : (v > hi) ? hi : v;
  endfunction

  function automatic int mv(input int p, input int d, input int hi);
    return clampi(p + (d != 0 ? 1 : -1), R, hi);
  endfunction

  task automatic model_step(input bit s, hu, hd, hl, hr, hb, rst);
    bit rise;
    m_tick = 1'b0;
    if (rst) begin
      m_mode = MIdle; m_cnt = 0; m_x = XS; m_y = YS; m_dx = 1; m_dy = 0;
      m_lives = LV; m_sq = 0;
      return;
    end
    rise = s && (m_sq == 0);
    m_sq = s;
    case (m_mode)
      MIdle: if (rise) begin m_mode = MRun; m_cnt = 0; end
      MRun: begin
        m_tick = (m_cnt == TD - 1);
        m_cnt  = m_tick ? 0 : m_cnt + 1;
        if (m_tick && m_y >= YMAX && !hb) begin
          m_mode = MLost; m_lives--; n_lost++;
        end else begin
          if (m_tick) begin
            if (hu && hd) m_dy = (m_dy == 0);
            else if (hu || hb) m_dy = 0;
            else if (hd) m_dy = 1;
            else if (m_y <= R) m_dy = 1;
            if (hl && hr) m_dx = (m_dx == 0);
            else if (hl) m_dx = 0;
            else if (hr) m_dx = 1;
            else if (m_x <= R) m_dx = 1;
            else if (m_x >= XMAX) m_dx = 0;
            m_x = mv(m_x, m_dx, XMAX);
            m_y = mv(m_y, m_dy, YMAX);
          end
          if (!s) m_mode = MIdle;
        end
      end
      MLost: begin
        m_x = XS; m_y = YS; m_dx = 1; m_dy = 0;
        m_mode = (m_lives == 0) ? MOver : MIdle;
      end
      default: ;
    endcase
  endtask

  task automatic compare_all();
    check_eq("x_ball", int'(bus.x_ball), m_x);
    check_eq("y_ball", int'(bus.y_ball), m_y);
    check_eq("next_x", int'(bus.next_x), mv(m_x, m_dx, XMAX));
    check_eq("next_y", int'(bus.next_y), mv(m_y, m_dy, YMAX));
    check_eq("dir_x", int'(bus.dir_x), m_dx);
    check_eq("dir_y", int'(bus.dir_y), m_dy);
    check_eq("ball_lost", int'(bus.ball_lost), int'(m_mode == MLost));
    check_eq("lives", int'(bus.lives), m_lives);
    check_eq("game_over", int'(bus.game_over), int'(m_mode == MOver));
  endtask

  // Drive one clock's inputs, advance the model, then compare on the falling edge.
  task automatic cycle(input bit s, hu, hd, hl, hr, hb, rst);
    bus.start = s; bus.hit_up = hu; bus.hit_down = hd;
    bus.hit_left = hl; bus.hit_right = hr; bus.hit_bar = hb; reset = rst;
    model_step(s, hu, hd, hl, hr, hb, rst);
    @(negedge clock);
    compare_all();
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_x"}, int'(bus.x_ball), 320);
    check_eq({tag, "_y"}, int'(bus.y_ball), 400);
    check_eq({tag, "_nx"}, int'(bus.next_x), 321);
    check_eq({tag, "_ny"}, int'(bus.next_y), 399);
    check_eq({tag, "_dx"}, int'(bus.dir_x), 1);
    check_eq({tag, "_dy"}, int'(bus.dir_y), 0);
    check_eq({tag, "_lives"}, int'(bus.lives), 3);
    check_eq({tag, "_over"}, int'(bus.game_over), 0);
  endtask

  initial begin
    int k;
    bit s, bar_once, hl, hr, hb;
    bus.tick_ext = 1'b0;
    n_lost = 0;

    // Reset and first move latency.
    cycle(0, 0, 0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 0, 0, 1);
    check_reset_vals("reset");
    cycle(0, 0, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0, 0);
    k = 1;
    while (m_x == XS && k < 20) begin cycle(1, 0, 0, 0, 0, 0, 0); k++; end
    check_eq("first_move_cycles", k, 5);
    check_eq("first_x", int'(bus.x_ball), 321);
    check_eq("first_y", int'(bus.y_ball), 399);
    check_eq("first_nx", int'(bus.next_x), 322);
    check_eq("first_ny", int'(bus.next_y), 398);

    // Right wall bounce.
    k = 0;
    while (m_x != XMAX && k < 3000) begin cycle(1, 0, 0, 0, 0, 0, 0); k++; end
    check_eq("reach_right_wall", int'(m_x == XMAX), 1);
    k = 0;
    while (m_x == XMAX && k < 10) begin cycle(1, 0, 0, 0, 0, 0, 0); k++; end
    check_eq("wall_x", int'(bus.x_ball), XMAX - 1);
    check_eq("wall_dir_x", int'(bus.dir_x), 0);

    // Random hits, pauses, bar contacts and occasional resets.
    cycle(0, 0, 0, 0, 0, 0, 1);
    s = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      if (m_mode == MIdle) begin
        if ($urandom_range(0, 7) == 0) s = ~s;
      end else if ($urandom_range(0, 99) == 0) s = ~s;
      hl = ($urandom_range(0, 15) == 0);
      hr = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 31) == 0) begin hl = 1'b1; hr = 1'b1; end
      hb = (m_y >= YMAX - 2) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 63) == 0);
      cycle(s, $urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0, hl, hr, hb,
            $urandom_range(0, 1499) == 0);
    end

    // One paddle save, then three losses to game over.
    cycle(0, 0, 0, 0, 0, 0, 1);
    n_lost = 0;
    s = 1'b0;
    bar_once = 1'b1;
    k = 0;
    while (m_mode != MOver && k < 40000) begin
      s  = (m_mode == MIdle) ? ~s : 1'b1;
      hb = bar_once && (m_y >= YMAX);
      cycle(s, 0, 0, 0, 0, hb, 0);
      if (bar_once && m_tick && hb) begin
        bar_once = 1'b0;
        check_eq("bar_y", int'(bus.y_ball), YMAX - 1);
        check_eq("bar_dir_y", int'(bus.dir_y), 0);
        check_eq("bar_no_loss", int'(bus.ball_lost), 0);
      end
      k++;
    end
    check_eq("reach_over", int'(m_mode == MOver), 1);
    check_eq("bar_seen", int'(bar_once), 0);
    check_eq("loss_count", n_lost, 3);
    check_eq("over_lives", int'(bus.lives), 0);
    check_eq("over_flag", int'(bus.game_over), 1);
    for (int i = 0; i < 8; i++) cycle(i[0], 0, 0, 0, 0, 0, 0);
    check_eq("over_sticky", int'(bus.game_over), 1);
    check_eq("over_frozen_x", int'(bus.x_ball), 320);

    // Reset in the middle of a run.
    cycle(0, 0, 0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 30; i++) cycle(1, 0, 0, 0, 0, 0, 0);
    check_eq("run_moved", int'(bus.x_ball != 10'd320), 1);
    cycle(1, 0, 0, 0, 0, 0, 1);
    check_reset_vals("midrun_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
